qc_issue_scheduler: RTL

Timed issue scheduler between the instruction-decode queue and the per-FPGA dispatch network. It pops decoded instruction words from the queue and waits until the global schedule time reaches each word's `start_time`. It then checks that every FPGA the instruction touches is idle, and issues the instruction once with a valid/ready handshake. A per-FPGA busy scoreboard is set on issue and cleared by completion pulses from the FPGAs.

---
 rtl/qc_issue_scheduler.sv | 131 +++++++++++++
 1 files changed

// File: rtl/qc_issue_scheduler.sv
// Timed issue scheduler: pops decoded words, waits for start_time and free FPGAs, issues once.
// One instruction in flight; busy scoreboard set on accept, cleared by fpga_done pulses.
module qc_issue_scheduler #(
  parameter int NUM_FPGA           = 64,
  parameter int NUM_QUBIT_PER_FPGA = 64,
  localparam int FB = $clog2(NUM_FPGA),
  localparam int LB = $clog2(NUM_QUBIT_PER_FPGA),
  localparam int QW = FB + LB,
  localparam int IW = 3*QW + 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [IW-1:0]       instr_data,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic                issue_valid,
  input  logic                issue_ready,
  output logic [1:0]          issue_op_code,
  output logic [FB-1:0]       issue_fpga_a,
  output logic [LB-1:0]       issue_qubit_a,
  output logic [FB-1:0]       issue_fpga_b,
  output logic [LB-1:0]       issue_qubit_b,
  output logic [QW-1:0]       issue_dest,
  output logic [15:0]         issue_time,
  input  logic [NUM_FPGA-1:0] fpga_done,
  output logic [NUM_FPGA-1:0] fpga_busy,
  output logic [15:0]         sched_time,
  output logic [15:0]         late_cnt,
  output logic                running
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, ISSUE} state_t;

  state_t              state, state_n;
  logic [IW-3:0]       word;
  logic                first_wait;
  logic                stop_pend;
  logic [15:0]         sched;
  logic [15:0]         late;
  logic [15:0]         itime;
  logic [NUM_FPGA-1:0] busy;
  logic [NUM_FPGA-1:0] req;

  logic [15:0]   w_start;
  logic [1:0]    w_op;
  logic [QW-1:0] w_op1, w_op2, w_dest;
  logic          time_ok, res_free, accept, stop_any;
  logic          unused_status;

  // status bits are carried by the queue but have no meaning here
  assign unused_status = ^instr_data[1:0];

  assign w_start = word[IW-3 -: 16];
  assign w_op    = word[IW-19 -: 2];
  assign w_op1   = word[3*QW-1 -: QW];
  assign w_op2   = word[2*QW-1 -: QW];
  assign w_dest  = word[QW-1:0];

  always_comb begin
    req = '0;
    case (w_op)
      2'b01, 2'b11: req[w_op1[QW-1:LB]] = 1'b1;
      2'b10: begin
        req[w_op1[QW-1:LB]] = 1'b1;
        req[w_op2[QW-1:LB]] = 1'b1;
      end
      default: req = '0;
    endcase
  end

  // a done pulse arriving this cycle already frees its FPGA for the WAIT decision
  assign time_ok  = (sched >= w_start);
  assign res_free = ((busy & ~fpga_done & req) == '0);
  assign accept   = (state == ISSUE) && issue_ready;
  assign stop_any = stop | stop_pend;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = FETCH;
      FETCH: begin
        if (instr_valid)   state_n = WAIT;
        else if (stop_any) state_n = IDLE;
      end
      WAIT:  if (time_ok && res_free) state_n = (w_op == 2'b00) ? FETCH : ISSUE;
      ISSUE: if (issue_ready) state_n = stop_any ? IDLE : FETCH;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word       <= '0;
      first_wait <= 1'b0;
      stop_pend  <= 1'b0;
      sched      <= '0;
      late       <= '0;
      itime      <= '0;
      busy       <= '0;
    end else begin
      state      <= state_n;
      first_wait <= (state == FETCH) && instr_valid;
      if ((state == FETCH) && instr_valid) word <= instr_data[IW-1:2];
      stop_pend  <= (state != IDLE) && (state_n != IDLE) && stop_any;
      if ((state == IDLE) || (state_n == IDLE)) sched <= '0;
      else if (sched != 16'hFFFF)               sched <= sched + 16'd1;
      if (first_wait && (w_start < sched) && (late != 16'hFFFF)) late <= late + 16'd1;
      if ((state == WAIT) && (state_n == ISSUE)) itime <= sched;
      // set on accept wins over a coincident clear
      busy <= (busy & ~fpga_done) | (accept ? req : '0);
    end
  end

  assign instr_ready   = (state == FETCH);
  assign issue_valid   = (state == ISSUE);
  assign issue_op_code = w_op;
  assign issue_fpga_a  = w_op1[QW-1:LB];
  assign issue_qubit_a = w_op1[LB-1:0];
  assign issue_fpga_b  = w_op2[QW-1:LB];
  assign issue_qubit_b = w_op2[LB-1:0];
  assign issue_dest    = w_dest;
  assign issue_time    = itime;
  assign fpga_busy     = busy;
  assign sched_time    = sched;
  assign late_cnt      = late;
  assign running       = (state != IDLE);

endmodule
